// File: rtl/sad_search_engine_if.sv
// Beat-in / result-out bundle of the SAD search engine.
// The driver of search beats uses master; the engine uses slave.
interface sad_search_engine_if #(
    parameter int NUM_THREADS = 4,
    parameter int PIX_W       = 9,
    parameter int WIN_DIM     = 4,
    parameter int IDX_W       = 16
);
    localparam int SAD_W = PIX_W + $clog2(WIN_DIM * WIN_DIM);

    logic                                          InValid;
    logic [IDX_W-1:0]                              Index;
    logic                                          FrameStart;
    logic                                          TriggerBoss;
    logic [WIN_DIM*WIN_DIM*PIX_W-1:0]              Window;
    logic [WIN_DIM*(WIN_DIM+NUM_THREADS-1)*PIX_W-1:0] Frame;
    logic                                          OutValid;
    logic [IDX_W-1:0]                              OutIndex;
    logic [SAD_W-1:0]                              OutValue;
    logic                                          BestDone;
    logic [IDX_W-1:0]                              BestIndex;
    logic [SAD_W-1:0]                              BestValue;

    modport master (
        output InValid, Index, FrameStart, TriggerBoss, Window, Frame,
        input  OutValid, OutIndex, OutValue, BestDone, BestIndex, BestValue
    );

    modport slave (
        input  InValid, Index, FrameStart, TriggerBoss, Window, Frame,
        output OutValid, OutIndex, OutValue, BestDone, BestIndex, BestValue
    );
endinterface

// File: rtl/sad_search_engine.sv
// Pipelined SAD block matcher: NUM_THREADS candidate positions per beat, a registered
// minimum tree picks the beat winner, and a tracker keeps the best result of a search.
module sad_search_engine #(
    parameter int NUM_THREADS = 4,
    parameter int PIX_W       = 9,
    parameter int WIN_DIM     = 4,
    parameter int FRAME_W     = 64,
    parameter int IDX_W       = 16
) (
    input  logic              clk,
    input  logic              Reset_n,
    sad_search_engine_if.slave bus
);
    localparam int NPIX    = WIN_DIM * WIN_DIM;
    localparam int ROW_PIX = WIN_DIM + NUM_THREADS - 1;
    localparam int LOG_NT  = $clog2(NUM_THREADS);
    localparam int SAD_W   = PIX_W + $clog2(NPIX);
    localparam int ROW_W   = PIX_W + $clog2(WIN_DIM);
    localparam int L       = 3 + LOG_NT;
    localparam int TW      = (LOG_NT > 0) ? LOG_NT : 1;
    localparam int NODES   = 2 * NUM_THREADS - 1;

    if (NUM_THREADS < 1 || NUM_THREADS > 16 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_threads
        $error("NUM_THREADS must be a power of two between 1 and 16");
    end
    if ((WIN_DIM & (WIN_DIM - 1)) != 0 || FRAME_W < ROW_PIX) begin : g_bad_geometry
        $error("WIN_DIM must be a power of two and FRAME_W must cover one frame slice row");
    end

    // Sideband: slot s travels with the data held in pipeline stage s+1.
    logic [L-1:0]            sb_valid_reg;
    logic [L-1:0]            sb_fs_reg;
    logic [L-1:0]            sb_tb_reg;
    logic [L-1:0][IDX_W-1:0] sb_idx_reg;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sb_valid_reg <= '0;
            sb_fs_reg    <= '0;
            sb_tb_reg    <= '0;
            sb_idx_reg   <= '0;
        end else begin
            sb_valid_reg <= {sb_valid_reg[L-2:0], bus.InValid};
            sb_fs_reg    <= {sb_fs_reg[L-2:0], bus.InValid & bus.FrameStart};
            sb_tb_reg    <= {sb_tb_reg[L-2:0], bus.InValid & bus.TriggerBoss};
            if (bus.InValid)
                sb_idx_reg[0] <= bus.Index;
            for (int s = 1; s < L; s++)
                if (sb_valid_reg[s-1])
                    sb_idx_reg[s] <= sb_idx_reg[s-1];
        end
    end

    logic [NUM_THREADS-1:0][NPIX-1:0][PIX_W-1:0]    diff_reg;
    logic [NUM_THREADS-1:0][WIN_DIM-1:0][ROW_W-1:0] row_sum_reg;
    logic [NODES-1:0][SAD_W-1:0]                    node_val_reg;
    logic [NODES-1:0][TW-1:0]                       node_thr_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
            for (gj = 0; gj < NPIX; gj++) begin : g_pix
                localparam int R = gj / WIN_DIM;
                localparam int C = gj % WIN_DIM;
                logic [PIX_W-1:0] win_pix;
                logic [PIX_W-1:0] frm_pix;
                assign win_pix = bus.Window[gj*PIX_W +: PIX_W];
                assign frm_pix = bus.Frame[(R*ROW_PIX + C + gi)*PIX_W +: PIX_W];
                always_ff @(posedge clk or negedge Reset_n) begin
                    if (!Reset_n)
                        diff_reg[gi][gj] <= '0;
                    else if (bus.InValid)
                        diff_reg[gi][gj] <= (win_pix > frm_pix) ? win_pix - frm_pix : frm_pix - win_pix;
                end
            end

            for (gj = 0; gj < WIN_DIM; gj++) begin : g_row
                logic [ROW_W-1:0] row_acc;
                always_comb begin
                    row_acc = '0;
                    for (int c = 0; c < WIN_DIM; c++)
                        row_acc = row_acc + ROW_W'(diff_reg[gi][gj*WIN_DIM + c]);
                end
                always_ff @(posedge clk or negedge Reset_n) begin
                    if (!Reset_n)
                        row_sum_reg[gi][gj] <= '0;
                    else if (sb_valid_reg[0])
                        row_sum_reg[gi][gj] <= row_acc;
                end
            end
        end

        // Heap-ordered tree: node n has children 2n+1 (lower threads) and 2n+2; leaves are threads.
        for (gi = 0; gi < NODES; gi++) begin : g_node
            if (gi >= NUM_THREADS - 1) begin : g_leaf
                localparam int K = gi - (NUM_THREADS - 1);
                logic [SAD_W-1:0] sad_acc;
                always_comb begin
                    sad_acc = '0;
                    for (int r = 0; r < WIN_DIM; r++)
                        sad_acc = sad_acc + SAD_W'(row_sum_reg[K][r]);
                end
                always_ff @(posedge clk or negedge Reset_n) begin
                    if (!Reset_n) begin
                        node_val_reg[gi] <= '0;
                        node_thr_reg[gi] <= '0;
                    end else if (sb_valid_reg[1]) begin
                        node_val_reg[gi] <= sad_acc;
                        node_thr_reg[gi] <= TW'(K);
                    end
                end
            end else begin : g_min
                localparam int EN = 1 + LOG_NT - ($clog2(gi + 2) - 1);
                logic left_wins;
                // Ties go left so the lower thread, hence the lower index, wins.
                assign left_wins = node_val_reg[2*gi+1] <= node_val_reg[2*gi+2];
                always_ff @(posedge clk or negedge Reset_n) begin
                    if (!Reset_n) begin
                        node_val_reg[gi] <= '0;
                        node_thr_reg[gi] <= '0;
                    end else if (sb_valid_reg[EN]) begin
                        node_val_reg[gi] <= left_wins ? node_val_reg[2*gi+1] : node_val_reg[2*gi+2];
                        node_thr_reg[gi] <= left_wins ? node_thr_reg[2*gi+1] : node_thr_reg[2*gi+2];
                    end
                end
            end
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} track_state_t;

    track_state_t     state_reg, state_next;
    logic [IDX_W-1:0] best_idx_reg, best_idx_next;
    logic [SAD_W-1:0] best_val_reg, best_val_next;
    logic             done_reg, done_next;
    logic [IDX_W-1:0] out_idx;
    logic             out_fs, out_tb;

    assign out_idx = sb_idx_reg[L-1] + IDX_W'(node_thr_reg[0]);
    assign out_fs  = sb_valid_reg[L-1] & sb_fs_reg[L-1];
    assign out_tb  = sb_valid_reg[L-1] & sb_tb_reg[L-1];

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            best_idx_reg <= '0;
            best_val_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            best_idx_reg <= best_idx_next;
            best_val_reg <= best_val_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        best_idx_next = best_idx_reg;
        best_val_next = best_val_reg;
        done_next     = 1'b0;
        if (sb_valid_reg[L-1]) begin
            if (out_fs || (state_reg == SEARCH && node_val_reg[0] < best_val_reg)) begin
                best_idx_next = out_idx;
                best_val_next = node_val_reg[0];
            end
            if (out_fs)
                state_next = SEARCH;
            if (out_tb && (out_fs || state_reg == SEARCH)) begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end
    end

    assign bus.OutValid  = sb_valid_reg[L-1];
    assign bus.OutIndex  = out_idx;
    assign bus.OutValue  = node_val_reg[0];
    assign bus.BestDone  = done_reg;
    assign bus.BestIndex = best_idx_reg;
    assign bus.BestValue = best_val_reg;
endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench for sad_search_engine: pipelined vector table plus search-tracker sequences.
module tb_sad_search_engine;
    localparam int NT   = 4;
    localparam int PW   = 9;
    localparam int WD   = 4;
    localparam int FW   = 64;
    localparam int IW   = 16;
    localparam int LAT  = 5;
    localparam int ROWP = WD + NT - 1;
    localparam int NVEC = 9;

    logic clk = 1'b0;
    logic Reset_n;
    always #5 clk = ~clk;

    sad_search_engine_if #(.NUM_THREADS(NT), .PIX_W(PW), .WIN_DIM(WD), .IDX_W(IW)) bus();

    sad_search_engine #(.NUM_THREADS(NT), .PIX_W(PW), .WIN_DIM(WD), .FRAME_W(FW), .IDX_W(IW)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit          valid;
        logic [15:0] idx;
        int          wb, wc, wr, fb, fc, fr, hc, hv;
        logic [15:0] exp_idx;
        int          exp_val;
    } vec_t;

    vec_t vecs[NVEC];
    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, ov_cnt = 0;
    logic [15:0] done_idx = '0;
    logic [12:0] done_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.BestDone === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_idx <= bus.BestIndex;
            done_val <= bus.BestValue;
        end
        if (bus.OutValid === 1'b1)
            ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [WD*WD*PW-1:0] make_window(int b, int c, int r);
        logic [WD*WD*PW-1:0] w;
        for (int i = 0; i < WD*WD; i++)
            w[i*PW +: PW] = PW'(b + c*(i % WD) + r*(i / WD));
        return w;
    endfunction

    function automatic logic [WD*ROWP*PW-1:0] make_frame(int b, int c, int r, int hc, int hv);
        logic [WD*ROWP*PW-1:0] f;
        for (int rr = 0; rr < WD; rr++)
            for (int cc = 0; cc < ROWP; cc++)
                f[(rr*ROWP + cc)*PW +: PW] = PW'(b + c*cc + r*rr + ((cc >= hc) ? hv : 0));
        return f;
    endfunction

    task automatic drive(input bit v, input bit fs, input bit tb, input logic [15:0] idx,
                         input int wb, input int wc, input int wr,
                         input int fb, input int fc, input int fr, input int hc, input int hv);
        bus.InValid     = v;
        bus.FrameStart  = fs;
        bus.TriggerBoss = tb;
        bus.Index       = idx;
        bus.Window      = make_window(wb, wc, wr);
        bus.Frame       = make_frame(fb, fc, fr, hc, hv);
    endtask

    task automatic uni(input bit fs, input bit tb, input logic [15:0] idx, input int w, input int f);
        drive(1'b1, fs, tb, idx, w, 0, 0, f, 0, 0, 99, 0);
    endtask

    // Window pixel (r,c) = c+s against frame column value: thread k scores 16*|s-k|.
    task automatic ramp(input bit fs, input bit tb, input logic [15:0] idx, input int s);
        drive(1'b1, fs, tb, idx, s, 1, 0, 0, 1, 0, 99, 0);
    endtask

    task automatic idle();
        bus.InValid     = 1'b0;
        bus.FrameStart  = 1'b0;
        bus.TriggerBoss = 1'b0;
    endtask

    task automatic check_search(input string name, input int c0, input int d0,
                                input int exp_dly, input int exp_idx, input int exp_val);
        check({name, " done count"}, done_cnt - d0, 1);
        check({name, " done cycle"}, done_cyc - c0, exp_dly);
        check({name, " BestIndex"}, done_idx, exp_idx);
        check({name, " BestValue"}, done_val, exp_val);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " OutValid"}, bus.OutValid, 0);
        check({name, " OutIndex"}, bus.OutIndex, 0);
        check({name, " OutValue"}, bus.OutValue, 0);
        check({name, " BestDone"}, bus.BestDone, 0);
        check({name, " BestIndex"}, bus.BestIndex, 0);
        check({name, " BestValue"}, bus.BestValue, 0);
    endtask

    initial begin
        int c0, d0, ov0;
        //          valid idx       wb  wc wr  fb fc fr  hc  hv  exp_idx exp_val
        vecs[0] = '{1'b1, 16'd100,  10, 0, 0,  10, 0, 0, 5,  2,  16'd100,  0};
        vecs[1] = '{1'b1, 16'd40,   10, 0, 0,  12, 0, 0, 99, 0,  16'd40,   32};
        vecs[2] = '{1'b1, 16'd7,    511,0, 0,  0,  0, 0, 99, 0,  16'd7,    8176};
        vecs[3] = '{1'b1, 16'd1000, 2,  1, 0,  0,  1, 0, 99, 0,  16'd1002, 0};
        vecs[4] = '{1'b1, 16'hFFFE, 5,  1, 0,  0,  1, 0, 99, 0,  16'h0001, 32};
        vecs[5] = '{1'b0, 16'h1234, 0,  0, 0,  9,  0, 0, 99, 0,  16'h0001, 32};
        vecs[6] = '{1'b1, 16'hFFFF, 3,  1, 0,  0,  1, 1, 99, 0,  16'h0000, 16};
        vecs[7] = '{1'b1, 16'd500,  0,  1, 0,  3,  1, 0, 99, 0,  16'd500,  48};
        vecs[8] = '{1'b1, 16'd200,  10, 0, 0,  0,  0, 0, 3,  10, 16'd203,  0};

        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'd0, 0, 0, 0, 0, 0, 0, 99, 0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        Reset_n = 1'b1;

        // Back-to-back table beats; bubbles carry both tags, which must be ignored.
        for (int t = 0; t < NVEC + LAT; t++) begin
            @(negedge clk);
            if (t >= LAT) begin
                check($sformatf("vec%0d OutValid", t - LAT), bus.OutValid, vecs[t-LAT].valid);
                check($sformatf("vec%0d OutIndex", t - LAT), bus.OutIndex, vecs[t-LAT].exp_idx);
                check($sformatf("vec%0d OutValue", t - LAT), bus.OutValue, vecs[t-LAT].exp_val);
            end
            if (t < NVEC)
                drive(vecs[t].valid, !vecs[t].valid, !vecs[t].valid, vecs[t].idx,
                      vecs[t].wb, vecs[t].wc, vecs[t].wr, vecs[t].fb, vecs[t].fc,
                      vecs[t].fr, vecs[t].hc, vecs[t].hv);
            else
                idle();
        end
        repeat (2) @(negedge clk);
        check("untagged beats no BestDone", done_cnt, 0);
        check("untagged beats BestIndex", bus.BestIndex, 0);

        // Running best: 48 then 16 then a tied 16 with TriggerBoss keeps index 4.
        @(negedge clk); c0 = cyc; d0 = done_cnt;
        uni(1'b1, 1'b0, 16'd0, 10, 13);
        @(negedge clk); uni(1'b0, 1'b0, 16'd4, 10, 11);
        @(negedge clk); uni(1'b0, 1'b1, 16'd8, 10, 11);
        @(negedge clk); idle();
        repeat (10) @(negedge clk);
        check_search("running best", c0, d0, 8, 4, 16);

        // One-beat search with index wrap, then an untagged beat must not touch Best.
        @(negedge clk); c0 = cyc; d0 = done_cnt;
        ramp(1'b1, 1'b1, 16'hFFFE, 5);
        @(negedge clk); idle();
        repeat (8) @(negedge clk);
        check_search("one-beat wrap", c0, d0, 6, 1, 32);
        @(negedge clk); uni(1'b0, 1'b0, 16'd77, 10, 10);
        @(negedge clk); idle();
        repeat (8) @(negedge clk);
        check("idle beat OutIndex", bus.OutIndex, 77);
        check("idle beat OutValue", bus.OutValue, 0);
        check("idle beat BestIndex held", bus.BestIndex, 1);
        check("idle beat BestValue held", bus.BestValue, 32);
        check("idle beat no BestDone", done_cnt - d0, 1);

        // A second FrameStart abandons the first search and reloads even with a larger SAD.
        @(negedge clk); c0 = cyc; d0 = done_cnt;
        uni(1'b1, 1'b0, 16'd10, 10, 13);
        @(negedge clk); uni(1'b1, 1'b0, 16'd20, 10, 14);
        @(negedge clk); uni(1'b0, 1'b1, 16'd30, 10, 15);
        @(negedge clk); idle();
        repeat (10) @(negedge clk);
        check_search("restart", c0, d0, 8, 20, 64);

        // Reset while SEARCH is active and three beats are still in the pipeline.
        @(negedge clk); d0 = done_cnt;
        uni(1'b1, 1'b0, 16'd50, 10, 11);
        for (int b = 1; b < 5; b++) begin
            @(negedge clk); uni(1'b0, b == 4, 16'(50 + b), 10, 10);
        end
        @(negedge clk); idle();
        @(negedge clk); Reset_n = 1'b0;
        #1 check_all_zero("mid-search reset");
        repeat (2) @(negedge clk);
        Reset_n = 1'b1; ov0 = ov_cnt;
        repeat (12) @(negedge clk);
        check("lost beats no OutValid", ov_cnt - ov0, 0);
        check("lost beats no BestDone", done_cnt - d0, 0);

        @(negedge clk); c0 = cyc; d0 = done_cnt;
        ramp(1'b1, 1'b1, 16'd300, 2);
        @(negedge clk); idle();
        repeat (10) @(negedge clk);
        check_search("after reset", c0, d0, 6, 302, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
